// File: rtl/goertzel_bin_scheduler.sv
// Multi-bin sequencer for a shared single-bin Goertzel core: replays one sample frame
// per enabled bin and returns one tagged magnitude per bin over a valid/ready stream.
module goertzel_bin_scheduler #(
    parameter int NBINS   = 8,
    parameter int NS_MAX  = 1024,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(NS_MAX),
    localparam int BW     = $clog2(NBINS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      ns_i,
    input  logic [NBINS-1:0] bin_en_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             cfg_we_i,
    input  logic [BW-1:0]    cfg_addr_i,
    input  logic [63:0]      cfg_alpha_i,
    input  logic [63:0]      cfg_cwre_i,
    input  logic [63:0]      cfg_cwim_i,
    output logic             smp_rd_o,
    output logic [AW-1:0]    smp_addr_o,
    input  logic [31:0]      smp_data_i,
    output logic             core_clr_o,
    output logic             core_en_o,
    output logic [31:0]      core_ns_o,
    output logic [63:0]      core_alpha_o,
    output logic [63:0]      core_cwre_o,
    output logic [63:0]      core_cwim_o,
    output logic [31:0]      core_data_o,
    input  logic             core_valid_i,
    input  logic [31:0]      core_res_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [BW-1:0]    res_bin_o,
    output logic [31:0]      res_data_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [63:0]      r_tbl_alpha [NBINS];
    logic [63:0]      r_tbl_cwre  [NBINS];
    logic [63:0]      r_tbl_cwim  [NBINS];

    logic [31:0]      r_ns;
    logic [AW-1:0]    r_last_addr;
    logic [NBINS-1:0] r_mask;
    logic [BW-1:0]    r_bin;
    logic [AW-1:0]    r_addr;
    logic [TW-1:0]    r_timer;
    logic [31:0]      r_res;
    logic [63:0]      r_core_alpha;
    logic [63:0]      r_core_cwre;
    logic [63:0]      r_core_cwim;
    logic             r_en_d;
    logic             r_done;
    logic             r_err;
    logic             r_abort_clr;

    logic             w_abort;
    logic             w_start;
    logic             w_ns_bad;
    logic             w_last_addr;
    logic             w_timeout;
    logic [AW-1:0]    w_ns_last;
    logic [NBINS-1:0] w_above;
    logic             w_has_next;
    logic [BW-1:0]    w_next_bin;
    logic [BW-1:0]    w_first_bin;

    assign w_abort     = abort_i && (r_state != S_IDLE);
    assign w_start     = start_i && !abort_i && (r_state == S_IDLE);
    assign w_ns_bad    = (ns_i == 32'd0) || (ns_i > 32'(NS_MAX));
    assign w_ns_last   = ns_i[AW-1:0] - AW'(1);
    assign w_last_addr = (r_addr == r_last_addr);
    assign w_timeout   = (r_timer == TW'(TIMEOUT - 1));

    // Bins still pending in this frame: enabled and above the current one
    genvar gi;
    generate
        for (gi = 0; gi < NBINS; gi++) begin : g_above
            assign w_above[gi] = r_mask[gi] && (BW'(gi) > r_bin);
        end
    endgenerate

    always_comb begin
        w_has_next = 1'b0;
        w_next_bin = '0;
        for (int i = NBINS - 1; i >= 0; i--) begin
            if (w_above[i]) begin
                w_has_next = 1'b1;
                w_next_bin = BW'(i);
            end
        end
    end

    always_comb begin
        w_first_bin = '0;
        for (int i = NBINS - 1; i >= 0; i--) begin
            if (bin_en_i[i]) begin
                w_first_bin = BW'(i);
            end
        end
    end

    // Coefficient table: writable any cycle, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBINS; i++) begin
                r_tbl_alpha[i] <= '0;
                r_tbl_cwre[i]  <= '0;
                r_tbl_cwim[i]  <= '0;
            end
        end else if (cfg_we_i && (int'(cfg_addr_i) < NBINS)) begin
            r_tbl_alpha[cfg_addr_i] <= cfg_alpha_i;
            r_tbl_cwre[cfg_addr_i]  <= cfg_cwre_i;
            r_tbl_cwim[cfg_addr_i]  <= cfg_cwim_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && !w_ns_bad && (bin_en_i != '0)) begin
                        w_state_next = S_CLEAR;
                    end
                end
                S_CLEAR: w_state_next = S_FEED;
                S_FEED: begin
                    if (w_last_addr) begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_valid_i) begin
                        w_state_next = S_OUT;
                    end else if (w_timeout) begin
                        w_state_next = w_has_next ? S_CLEAR : S_IDLE;
                    end
                end
                S_OUT: begin
                    if (res_ready_i) begin
                        w_state_next = w_has_next ? S_CLEAR : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (r_state != S_IDLE);
        smp_rd_o    = (r_state == S_FEED);
        core_clr_o  = (r_state == S_CLEAR) || r_abort_clr;
        res_valid_o = (r_state == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ns         <= '0;
            r_last_addr  <= '0;
            r_mask       <= '0;
            r_bin        <= '0;
            r_addr       <= '0;
            r_timer      <= '0;
            r_res        <= '0;
            r_core_alpha <= '0;
            r_core_cwre  <= '0;
            r_core_cwim  <= '0;
            r_en_d       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_abort_clr  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_abort_clr <= 1'b0;
            // Sample RAM returns data one cycle after the read strobe
            r_en_d      <= (r_state == S_FEED) && !w_abort;
            if (w_abort) begin
                r_abort_clr <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            if (w_ns_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_ns        <= ns_i;
                                r_last_addr <= w_ns_last;
                                r_mask      <= bin_en_i;
                                r_bin       <= w_first_bin;
                                if (bin_en_i == '0) begin
                                    r_done <= 1'b1;
                                end
                            end
                        end
                    end
                    S_CLEAR: begin
                        r_core_alpha <= r_tbl_alpha[r_bin];
                        r_core_cwre  <= r_tbl_cwre[r_bin];
                        r_core_cwim  <= r_tbl_cwim[r_bin];
                        r_addr       <= '0;
                        r_timer      <= '0;
                    end
                    S_FEED: begin
                        if (!w_last_addr) begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                    S_WAIT: begin
                        if (core_valid_i) begin
                            r_res <= core_res_i;
                        end else if (w_timeout) begin
                            r_err <= 1'b1;
                            if (w_has_next) begin
                                r_bin <= w_next_bin;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                    S_OUT: begin
                        if (res_ready_i) begin
                            if (w_has_next) begin
                                r_bin <= w_next_bin;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done_o       = r_done;
    assign err_o        = r_err;
    assign smp_addr_o   = r_addr;
    assign core_en_o    = r_en_d;
    assign core_data_o  = r_en_d ? smp_data_i : 32'd0;
    assign core_ns_o    = r_ns;
    assign core_alpha_o = r_core_alpha;
    assign core_cwre_o  = r_core_cwre;
    assign core_cwim_o  = r_core_cwim;
    assign res_bin_o    = r_bin;
    assign res_data_o   = r_res;

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Randomised bench for goertzel_bin_scheduler: sample RAM and a stand-in core surround the DUT;
// each frame is predicted from the coefficient table and RAM contents.
module tb_goertzel_bin_scheduler;
    localparam int NBINS   = 8;
    localparam int NS_MAX  = 1024;
    localparam int TIMEOUT = 64;
    localparam int AW      = 10;
    localparam int BW      = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i, abort_i;
    logic [31:0]      ns_i;
    logic [NBINS-1:0] bin_en_i;
    logic             busy_o, done_o, err_o;
    logic             cfg_we_i;
    logic [BW-1:0]    cfg_addr_i;
    logic [63:0]      cfg_alpha_i, cfg_cwre_i, cfg_cwim_i;
    logic             smp_rd_o;
    logic [AW-1:0]    smp_addr_o;
    logic [31:0]      smp_data_i;
    logic             core_clr_o, core_en_o;
    logic [31:0]      core_ns_o;
    logic [63:0]      core_alpha_o, core_cwre_o, core_cwim_o;
    logic [31:0]      core_data_o;
    logic             core_valid_i;
    logic [31:0]      core_res_i;
    logic             res_valid_o, res_ready_i;
    logic [BW-1:0]    res_bin_o;
    logic [31:0]      res_data_o;

    always #5 clk = ~clk;

    goertzel_bin_scheduler #(.NBINS(NBINS), .NS_MAX(NS_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .ns_i(ns_i),
        .bin_en_i(bin_en_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_alpha_i(cfg_alpha_i),
        .cfg_cwre_i(cfg_cwre_i), .cfg_cwim_i(cfg_cwim_i), .smp_rd_o(smp_rd_o),
        .smp_addr_o(smp_addr_o), .smp_data_i(smp_data_i), .core_clr_o(core_clr_o),
        .core_en_o(core_en_o), .core_ns_o(core_ns_o), .core_alpha_o(core_alpha_o),
        .core_cwre_o(core_cwre_o), .core_cwim_o(core_cwim_o), .core_data_o(core_data_o),
        .core_valid_i(core_valid_i), .core_res_i(core_res_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_bin_o(res_bin_o), .res_data_o(res_data_o)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [NS_MAX];
    logic [63:0] tbl_a [NBINS];
    logic [63:0] tbl_r [NBINS];
    logic [63:0] tbl_i [NBINS];

    // Order-sensitive digest the stand-in core reports for a bin
    function automatic logic [31:0] fold(input logic [31:0] h, input logic [31:0] n,
                                         input logic [63:0] a, input logic [63:0] r,
                                         input logic [63:0] i);
        return h + n * 32'h9E37 + a[31:0] * 32'd3 + r[31:0] * 32'd5 + i[31:0] * 32'd7
                 + a[63:32] * 32'd11 + r[63:32] * 32'd13 + i[63:32] * 32'd17;
    endfunction

    function automatic logic [31:0] model_res(input int ns, input int b);
        logic [31:0] h = 32'd0;
        for (int k = 0; k < ns; k++) h = h * 32'd31 + mem[k];
        return fold(h, 32'(ns), tbl_a[b], tbl_r[b], tbl_i[b]);
    endfunction

    // Synchronous-read sample RAM
    always @(posedge clk) if (smp_rd_o) smp_data_i <= mem[smp_addr_o];

    // Stand-in core: digests samples, raises valid some cycles after the ns-th sample
    logic [31:0] c_acc, c_cnt;
    logic [63:0] c_a, c_r, c_i;
    int c_wait;
    int clr_seq;
    int dead_seq = -1;
    int core_lat = 0;
    always @(posedge clk) begin
        if (rst) begin
            c_acc <= 0; c_cnt <= 0; c_wait <= 0; core_valid_i <= 0; core_res_i <= 0; clr_seq <= 0;
        end else if (core_clr_o) begin
            c_acc <= 0; c_cnt <= 0; c_wait <= 0; core_valid_i <= 0; clr_seq <= clr_seq + 1;
        end else if (core_en_o) begin
            c_acc <= c_acc * 32'd31 + core_data_o;
            c_cnt <= c_cnt + 1;
            if (c_cnt == 0) begin
                c_a <= core_alpha_o; c_r <= core_cwre_o; c_i <= core_cwim_o;
            end
        end else if (c_cnt != 0 && c_cnt == core_ns_o && !core_valid_i && clr_seq != dead_seq) begin
            if (c_wait >= core_lat) begin
                core_valid_i <= 1'b1;
                core_res_i   <= fold(c_acc, c_cnt, c_a, c_r, c_i);
            end else begin
                c_wait <= c_wait + 1;
            end
        end
    end

    // Result-stream ready driver
    logic rdy_random = 1'b1;
    logic rdy_val = 1'b1;
    initial begin
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            res_ready_i = rdy_random ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Event monitor
    int mon_cyc = 0, clr_cnt = 0, en_cnt = 0, err_cnt = 0, done_cnt = 0;
    int err_gap = 0, last_en = 0, res_n = 0;
    logic [BW-1:0] res_bin_a [4096];
    logic [31:0]   res_data_a [4096];
    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (core_clr_o) clr_cnt <= clr_cnt + 1;
        if (core_en_o) begin en_cnt <= en_cnt + 1; last_en <= mon_cyc; end
        if (err_o) begin err_cnt <= err_cnt + 1; err_gap <= mon_cyc - last_en; end
        if (done_o) done_cnt <= done_cnt + 1;
        if (res_valid_o && res_ready_i) begin
            res_bin_a[res_n]  <= res_bin_o;
            res_data_a[res_n] <= res_data_o;
            res_n <= res_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 0; abort_i = 0; ns_i = 0; bin_en_i = 0;
        cfg_we_i = 0; cfg_addr_i = 0; cfg_alpha_i = 0; cfg_cwre_i = 0; cfg_cwim_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int b = 0; b < NBINS; b++) begin tbl_a[b] = 0; tbl_r[b] = 0; tbl_i[b] = 0; end
    endtask

    task automatic write_cfg(input int b);
        cfg_we_i = 1; cfg_addr_i = BW'(b);
        cfg_alpha_i = {$urandom, $urandom}; cfg_cwre_i = {$urandom, $urandom}; cfg_cwim_i = {$urandom, $urandom};
        tbl_a[b] = cfg_alpha_i; tbl_r[b] = cfg_cwre_i; tbl_i[b] = cfg_cwim_i;
        @(posedge clk); #1;
        cfg_we_i = 0;
    endtask

    int exp_bin [NBINS];
    logic [31:0] exp_data [NBINS];
    int exp_n, exp_err, f_ns;
    logic [NBINS-1:0] f_mask;
    int b_done, b_err, b_clr, b_en, b_res;

    task automatic start_frame(input int ns, input logic [NBINS-1:0] mask, input bit dead);
        bit first = 1;
        exp_n = 0; exp_err = 0;
        for (int b = 0; b < NBINS; b++) begin
            if (mask[b]) begin
                if (dead && first) exp_err++;
                else begin exp_bin[exp_n] = b; exp_data[exp_n] = model_res(ns, b); exp_n++; end
                first = 0;
            end
        end
        b_done = done_cnt; b_err = err_cnt; b_clr = clr_cnt; b_en = en_cnt; b_res = res_n;
        dead_seq = dead ? clr_seq + 1 : -1;
        core_lat = $urandom_range(0, 4);
        f_ns = ns; f_mask = mask;
        start_i = 1; ns_i = ns; bin_en_i = mask;
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic finish_frame();
        int n = 0;
        int nb = $countones(f_mask);
        while (done_cnt == b_done && n < 4000 + nb * (f_ns + 200)) begin @(negedge clk); n++; end
        chk("done_pulse", done_cnt - b_done, 1);
        repeat (2) @(negedge clk);
        chk("busy_end", busy_o, 0);
        chk("res_count", res_n - b_res, exp_n);
        for (int i = 0; i < exp_n && i < res_n - b_res; i++) begin
            chk("res_bin", res_bin_a[b_res + i], exp_bin[i]);
            chk("res_data", res_data_a[b_res + i], exp_data[i]);
        end
        chk("clr_count", clr_cnt - b_clr, nb);
        chk("en_count", en_cnt - b_en, f_ns * nb);
        chk("err_count", err_cnt - b_err, exp_err);
        $display("frame ns=%0d mask=%b results=%0d errs=%0d", f_ns, f_mask, res_n - b_res, err_cnt - b_err);
        dead_seq = -1;
    endtask

    initial begin
        int n, bad, c0;
        logic [BW-1:0] cap_bin;
        logic [31:0] cap_data;
        logic [NBINS-1:0] m;
        for (int k = 0; k < NS_MAX; k++) mem[k] = $urandom;
        do_reset();

        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_smp_rd", smp_rd_o, 0);
        chk("rst_core_clr", core_clr_o, 0);
        chk("rst_core_en", core_en_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_core_ns", core_ns_o, 0);
        chk("rst_core_alpha", core_alpha_o, 0);
        chk("rst_smp_addr", smp_addr_o, 0);
        chk("rst_res_data", res_data_o, 0);
        @(posedge clk); #1;

        for (int b = 0; b < 3; b++) write_cfg(b);
        start_frame(4, 8'b0000_0111, 0); finish_frame();

        for (int b = 3; b < NBINS; b++) write_cfg(b);
        start_frame(16, 8'b0010_0100, 0); finish_frame();

        // Result held under back-pressure
        rdy_random = 0; rdy_val = 0;
        start_frame(4, 8'b0000_0011, 0);
        n = 0;
        while (!res_valid_o && n < 300) begin @(negedge clk); n++; end
        chk("hold_valid_seen", res_valid_o, 1);
        cap_bin = res_bin_o; cap_data = res_data_o; c0 = clr_cnt; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid_o !== 1'b1 || res_bin_o !== cap_bin || res_data_o !== cap_data) bad++;
        end
        chk("hold_stable", bad, 0);
        chk("hold_no_clr", clr_cnt - c0, 0);
        chk("hold_bin", cap_bin, exp_bin[0]);
        chk("hold_data", cap_data, exp_data[0]);
        rdy_random = 1;
        finish_frame();

        // Illegal frame lengths
        for (int t = 0; t < 2; t++) begin
            b_err = err_cnt; b_clr = clr_cnt;
            start_i = 1; ns_i = (t == 0) ? 0 : NS_MAX + 1; bin_en_i = 8'hFF;
            @(posedge clk); #1;
            start_i = 0;
            @(negedge clk);
            chk("badns_err_pulse", err_o, 1);
            chk("badns_busy", busy_o, 0);
            repeat (3) @(negedge clk);
            chk("badns_err_count", err_cnt - b_err, 1);
            chk("badns_no_clr", clr_cnt - b_clr, 0);
            $display("badns ns=%0d errs=%0d", ns_i, err_cnt - b_err);
            @(posedge clk); #1;
        end

        // Core never answers for the first bin
        start_frame(6, 8'b0000_0110, 1); finish_frame();
        chk("timeout_gap", err_gap, TIMEOUT);

        // Abort in FEED at addr 5 together with a start request
        b_done = done_cnt;
        start_i = 1; ns_i = 20; bin_en_i = 8'b0000_0011;
        @(posedge clk); #1;
        start_i = 0;
        n = 0;
        while (!(smp_rd_o && smp_addr_o == 5) && n < 100) begin @(negedge clk); n++; end
        chk("abort_at_addr5", smp_addr_o, 5);
        abort_i = 1; start_i = 1; ns_i = 4; bin_en_i = 8'b0000_0001;
        @(posedge clk); #1;
        abort_i = 0; start_i = 0;
        c0 = clr_cnt;
        @(negedge clk);
        chk("abort_busy", busy_o, 0);
        chk("abort_clr", core_clr_o, 1);
        chk("abort_res_valid", res_valid_o, 0);
        @(negedge clk);
        chk("abort_clr_once", core_clr_o, 0);
        chk("abort_start_ignored", busy_o, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - b_done, 0);
        chk("abort_clr_count", clr_cnt - c0, 1);
        $display("abort done=%0d clr=%0d", done_cnt - b_done, clr_cnt - c0);
        @(posedge clk); #1;

        // Table writes while busy: already-started bin keeps old coefficients
        write_cfg(0); write_cfg(2);
        start_frame(8, 8'b0000_0101, 0);
        n = 0;
        while (en_cnt == b_en && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        write_cfg(2);
        exp_data[1] = model_res(8, 2);
        write_cfg(0);
        finish_frame();

        start_frame(5, 8'b0000_0000, 0); finish_frame();
        start_frame(1, 8'b1001_0010, 0); finish_frame();
        start_frame(NS_MAX, 8'b1000_0001, 0); finish_frame();

        for (int t = 0; t < 6; t++) begin
            m = NBINS'($urandom_range(0, 255));
            start_frame($urandom_range(1, 48), m, (m != 0) && ($urandom_range(0, 3) == 0));
            finish_frame();
        end

        // Reset mid-frame also clears the table
        start_i = 1; ns_i = 30; bin_en_i = 8'hFF;
        @(posedge clk); #1;
        start_i = 0;
        repeat (50) @(posedge clk);
        #1 do_reset();
        @(negedge clk);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_core_alpha", core_alpha_o, 0);
        @(posedge clk); #1;
        start_frame(3, 8'b0000_0011, 0); finish_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
